// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename tags.
// Commit writes land here from the ROB, the decoder records renames at issue,
// and two combinational query ports return either a ready value or the tag of
// the ROB entry that will produce it. A flush wipes every pending rename.
module regfile_rename #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int ROB_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [REG_W-1:0]  issue_rd,
  input  logic [ROB_W-1:0]  issue_tag,
  input  logic              commit_valid,
  input  logic [REG_W-1:0]  commit_rd,
  input  logic [ROB_W-1:0]  commit_tag,
  input  logic [DATA_W-1:0] commit_value,
  input  logic              flush,
  input  logic [REG_W-1:0]  query_rs1,
  input  logic [REG_W-1:0]  query_rs2,
  output logic [DATA_W-1:0] out_value1,
  output logic [ROB_W-1:0]  out_tag1,
  output logic [DATA_W-1:0] out_value2,
  output logic [ROB_W-1:0]  out_tag2
);

  localparam int NREG = 1 << REG_W;

  // Entry 0 is reset to zero and never written, so x0 always reads 0/0.
  logic [DATA_W-1:0] value_q [NREG];
  logic [ROB_W-1:0]  tag_q   [NREG];

  // Register-file update: commit writes values, issue/commit/flush steer tags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (commit_valid && commit_rd == REG_W'(i)) begin
          value_q[i] <= commit_value;
        end
        // A flush discards all speculation, including this cycle's issue.
        // An issue rename outranks a same-cycle commit so the newest producer
        // is kept; commit only clears the tag if no younger rename replaced it.
        if (flush) begin
          tag_q[i] <= '0;
        end else if (issue_valid && issue_rd == REG_W'(i) && issue_tag != '0) begin
          tag_q[i] <= issue_tag;
        end else if (commit_valid && commit_rd == REG_W'(i) && tag_q[i] == commit_tag) begin
          tag_q[i] <= '0;
        end
      end
    end
  end

  // Source 1 lookup, with same-cycle commit bypass when the committer is the
  // register's current producer.
  always_comb begin
    out_value1 = '0;
    out_tag1   = '0;
    if (query_rs1 != '0) begin
      if (commit_valid && commit_rd == query_rs1 &&
          commit_tag == tag_q[query_rs1] && tag_q[query_rs1] != '0) begin
        out_value1 = commit_value;
        out_tag1   = '0;
      end else begin
        out_value1 = value_q[query_rs1];
        out_tag1   = tag_q[query_rs1];
      end
    end
  end

  // Source 2 lookup, identical to source 1 but fully independent.
  always_comb begin
    out_value2 = '0;
    out_tag2   = '0;
    if (query_rs2 != '0) begin
      if (commit_valid && commit_rd == query_rs2 &&
          commit_tag == tag_q[query_rs2] && tag_q[query_rs2] != '0) begin
        out_value2 = commit_value;
        out_tag2   = '0;
      end else begin
        out_value2 = value_q[query_rs2];
        out_tag2   = tag_q[query_rs2];
      end
    end
  end

endmodule

// File: doc/regfile_rename.md
Name: regfile_rename

Overview:
- Architectural register file with per-register rename tags; the receiving end of the ROB commit interface.
- Accepts in-order commit writes (register index, ROB tag, value) from the ROB.
- Records new renames from the decoder at issue.
- Answers the decoder's two source-operand queries combinationally, with either a value or the producing ROB tag.
- Clears all renames on ROB flush (branch mispredict).

Parameters:
- DATA_W, 32, data width
- REG_W, 5, register index width (32 registers, x0 hardwired zero)
- ROB_W, 4, ROB tag width; tag 0 is the null tag, meaning "no pending producer"

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- issue_valid  in  1  decoder allocates a ROB entry this cycle
- issue_rd  in  REG_W  destination of the issuing instruction
- issue_tag  in  ROB_W  ROB tag allocated to it
- commit_valid  in  1  ROB retires a register-writing entry this cycle
- commit_rd  in  REG_W  destination being committed
- commit_tag  in  ROB_W  ROB tag of the committing entry
- commit_value  in  DATA_W  result value
- flush  in  1  mispredict; discard all speculative renames
- query_rs1  in  REG_W  source 1 index
- query_rs2  in  REG_W  source 2 index
- out_value1  out  DATA_W  source 1 value (valid when out_tag1==0)
- out_tag1  out  ROB_W  source 1 pending producer tag, 0 if ready
- out_value2  out  DATA_W  source 2 value
- out_tag2  out  ROB_W  source 2 pending producer tag

Behaviour:
- Storage:
  - value[1..31] (DATA_W) and tag[1..31] (ROB_W).
  - x0 is not stored: it always reads value 0, tag 0, and writes and renames to it are dropped.
- Reset (asynchronous, immediate on rst high, independent of clk): all value=0 and all tag=0, so all outputs read 0/0. Reset mid-stream discards any in-flight issue or commit.
- Issue, on posedge: if issue_valid && !flush && issue_rd!=0 && issue_tag!=0, then tag[issue_rd] <= issue_tag. Otherwise no effect.
- Commit, on posedge: if commit_valid && commit_rd!=0:
  - value[commit_rd] <= commit_value, always.
  - tag[commit_rd] <= 0 only if tag[commit_rd]==commit_tag, i.e. no younger rename exists.
- Issue and commit to the same rd in the same cycle: the issue rename wins (tag <= issue_tag), and the value still updates.
- Flush, on posedge: all tags <= 0.
  - A same-cycle commit still writes its value; this is the mispredicted branch's predecessor retiring.
  - A same-cycle issue is ignored.
- Query: purely combinational, zero latency. For each port:
  - rs==0: value 0, tag 0.
  - If commit_valid && commit_rd==rs && commit_tag==tag[rs] && tag[rs]!=0: bypass, giving value=commit_value, tag=0.
  - Else if tag[rs]!=0: tag=tag[rs], value=value[rs]. The value is stale; the consumer must ignore it.
  - Else: value=value[rs], tag=0.
- A same-cycle issue does not affect the query result. The query reflects state before the issuing instruction's own rename, so "add x1,x1,x2" reads x1's old producer.
- The two query ports are independent; rs1==rs2 returns identical results.
- Tag width rule: the ROB never has two live entries with the same tag, so comparing tags is sufficient. Wrap-around reuse of a tag after commit is safe because commit clears the tag before reuse.
- Output data and tag are in the same cycle as the query; there is no handshake.

Test Plan:
- Reset:
  - Assert rst asynchronously mid-cycle after writes → all queries on x1..x31 immediately return value 0, tag 0.
  - x0 query always returns 0/0, even after commit_rd=0 with value 0xDEADBEEF.
- Rename then commit:
  - Issue rd=5 tag=3 → next cycle query rs1=5 gives tag 3.
  - Then commit rd=5 tag=3 value=0x1234 → same-cycle query gives value 0x1234, tag 0 (bypass).
  - Next cycle it gives the same from storage.
- Younger rename survives:
  - Issue rd=7 tag=2, then issue rd=7 tag=4.
  - Commit rd=7 tag=2 value=0x55 → value[7]=0x55, but the query still returns tag 4, and there is no bypass.
- Same-cycle issue and commit to the same rd:
  - Tag[9]=1; in one cycle commit rd=9 tag=1 value=0xA and issue rd=9 tag=6.
  - The same-cycle query returns the bypass 0xA with tag 0.
  - The next cycle returns tag 6.
- Flush:
  - Tags x3=2, x4=5; assert flush together with commit rd=3 tag=2 value=0x77 and issue rd=8 tag=6.
  - Next cycle: x3 gives 0x77 tag 0, x4 gives tag 0, and x8 gives tag 0 (issue dropped).
- Self-dependent issue: tag[1]=5; issue rd=1 tag=6 with query rs1=1 → the same-cycle query returns tag 5, and the next cycle returns tag 6.
